// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared FSM encoding and default sizing for the prediction vote filter
package vote_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_VOTE   = 2'd2,
      S_OUT    = 2'd3
   } state_t;

   localparam int DEF_NUM_CLASSES = 3;
   localparam int DEF_CLASS_WIDTH = 2;
   localparam int DEF_WINDOW      = 5;
   localparam int DEF_CNT_WIDTH   = 3;

   // A window of depth 1 still needs a one-bit pointer register.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/vote_argmax.sv
// rtl/vote_argmax.sv - combinational max over the per-class vote counters with newest-wins tie-break
module vote_argmax
   import vote_pkg::*;
#(
   parameter int NUM_CLASSES = DEF_NUM_CLASSES,
   parameter int CLASS_WIDTH = DEF_CLASS_WIDTH,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic [NUM_CLASSES*CNT_WIDTH-1:0] cnt_i,
   input  logic [CLASS_WIDTH-1:0]           newest_i,
   output logic [CLASS_WIDTH-1:0]           class_o,
   output logic [CNT_WIDTH-1:0]             votes_o
);

   logic [CNT_WIDTH-1:0]   best;
   logic [CLASS_WIDTH-1:0] best_cls;
   logic                   newest_tied;

   // Strict '>' keeps the lowest index among equal maxima; the newest class then overrides if tied.
   always_comb begin
      best        = '0;
      best_cls    = '0;
      newest_tied = 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (cnt_i[i*CNT_WIDTH +: CNT_WIDTH] > best) begin
            best     = cnt_i[i*CNT_WIDTH +: CNT_WIDTH];
            best_cls = CLASS_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if ((newest_i == CLASS_WIDTH'(i)) && (cnt_i[i*CNT_WIDTH +: CNT_WIDTH] == best)) begin
            newest_tied = 1'b1;
         end
      end
      class_o = newest_tied ? newest_i : best_cls;
      votes_o = best;
   end

endmodule

// File: rtl/prediction_vote_filter.sv
// rtl/prediction_vote_filter.sv - sliding-window majority vote over argmax class predictions
module prediction_vote_filter
   import vote_pkg::*;
#(
   parameter int NUM_CLASSES  = DEF_NUM_CLASSES,
   parameter int CLASS_WIDTH  = DEF_CLASS_WIDTH,
   parameter int WINDOW       = DEF_WINDOW,
   parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
   parameter int EMIT_PARTIAL = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [CLASS_WIDTH-1:0] i_class,
   input  logic                   i_flush,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [CLASS_WIDTH-1:0] o_class,
   output logic [CNT_WIDTH-1:0]   o_votes,
   output logic                   o_window_full,
   output logic                   o_drop
);

   localparam int                   PTR_WIDTH = ptr_width(WINDOW);
   localparam logic [CNT_WIDTH-1:0] FILL_MAX  = CNT_WIDTH'(WINDOW);
   localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(WINDOW - 1);

   state_t                           state_q, state_d;
   logic [CLASS_WIDTH-1:0]           buf_q [WINDOW];
   logic [PTR_WIDTH-1:0]             wr_ptr_q, wr_ptr_d;
   logic [CNT_WIDTH-1:0]             fill_q, fill_d;
   logic [CNT_WIDTH-1:0]             cnt_q [NUM_CLASSES];
   logic [CNT_WIDTH-1:0]             cnt_d [NUM_CLASSES];
   logic [NUM_CLASSES*CNT_WIDTH-1:0] cnt_flat;
   logic [CLASS_WIDTH-1:0]           new_q;
   logic [CLASS_WIDTH-1:0]           old_class;
   logic [CLASS_WIDTH-1:0]           o_class_q;
   logic [CNT_WIDTH-1:0]             o_votes_q;
   logic                             full_q;
   logic                             drop_q;
   logic [CLASS_WIDTH-1:0]           win_class;
   logic [CNT_WIDTH-1:0]             win_votes;
   logic                             accept;
   logic                             class_ok;
   logic                             window_full;
   logic                             emit;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: flush wins from any state; out-of-range classes never leave S_IDLE.
   always_comb begin
      state_d = state_q;
      if (i_flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (accept && class_ok) state_d = S_UPDATE;
            S_UPDATE: state_d = S_VOTE;
            S_VOTE:   state_d = emit ? S_OUT : S_IDLE;
            S_OUT:    if (o_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Handshake and decode outputs derived from the current state.
   always_comb begin
      i_ready     = (state_q == S_IDLE);
      o_valid     = (state_q == S_OUT);
      accept      = i_ready && i_valid && !i_flush;
      class_ok    = (int'(i_class) < NUM_CLASSES);
      window_full = (fill_q == FILL_MAX);
      emit        = (EMIT_PARTIAL != 0) || window_full;
   end

   // Window bookkeeping: evict the oldest vote only once the window is full, then count the new one.
   always_comb begin
      old_class = buf_q[wr_ptr_q];
      wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      fill_d    = window_full ? fill_q : fill_q + 1'b1;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         cnt_d[c] = cnt_q[c];
         if (window_full && (old_class == CLASS_WIDTH'(c))) begin
            cnt_d[c] = cnt_d[c] - 1'b1;
         end
         if (new_q == CLASS_WIDTH'(c)) begin
            cnt_d[c] = cnt_d[c] + 1'b1;
         end
         cnt_flat[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q[c];
      end
   end

   vote_argmax #(
      .NUM_CLASSES (NUM_CLASSES),
      .CLASS_WIDTH (CLASS_WIDTH),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_argmax (
      .cnt_i    (cnt_flat),
      .newest_i (new_q),
      .class_o  (win_class),
      .votes_o  (win_votes)
   );

   // Sample history: contents are only read after being written, so no reset is needed.
   always_ff @(posedge clk) begin
      if (!rst && !i_flush && (state_q == S_UPDATE)) begin
         buf_q[wr_ptr_q] <= new_q;
      end
   end

   // Counters, fill level, latched prediction and the registered result/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         fill_q    <= '0;
         new_q     <= '0;
         o_class_q <= '0;
         o_votes_q <= '0;
         full_q    <= 1'b0;
         drop_q    <= 1'b0;
         for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
      end else if (i_flush) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
         full_q   <= 1'b0;
         drop_q   <= 1'b0;
         for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= '0;
      end else begin
         drop_q <= 1'b0;
         if (accept) begin
            if (class_ok) begin
               new_q <= i_class;
            end else begin
               drop_q <= 1'b1;
            end
         end
         if (state_q == S_UPDATE) begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            full_q   <= (fill_d == FILL_MAX);
            for (int c = 0; c < NUM_CLASSES; c++) cnt_q[c] <= cnt_d[c];
         end
         if (state_q == S_VOTE) begin
            o_class_q <= win_class;
            o_votes_q <= win_votes;
         end
      end
   end

   assign o_class       = o_class_q;
   assign o_votes       = o_votes_q;
   assign o_window_full = full_q;
   assign o_drop        = drop_q;

endmodule

// File: tb/tb_prediction_vote_filter.sv
// tb/tb_prediction_vote_filter.sv - self-checking bench for prediction_vote_filter
module tb_prediction_vote_filter;

   localparam int NC  = 3;
   localparam int WIN = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [1:0] cls;
   logic       flush;
   logic       ordy;
   logic       sel;

   logic       a_ready, a_ov, a_full, a_drop;
   logic [1:0] a_class;
   logic [2:0] a_votes;
   logic       b_ready, b_ov, b_full, b_drop;
   logic [1:0] b_class;
   logic [2:0] b_votes;

   logic       rdy, ov, ofull, odrop;
   logic [1:0] ocls;
   logic [2:0] ovotes;

   int tests = 0;
   int fails = 0;
   int win[$];

   always #5 clk = ~clk;

   prediction_vote_filter #(
      .NUM_CLASSES(NC), .CLASS_WIDTH(2), .WINDOW(WIN), .CNT_WIDTH(3), .EMIT_PARTIAL(1)
   ) dut_a (
      .clk(clk), .rst(rst), .i_valid(valid & ~sel), .i_ready(a_ready), .i_class(cls),
      .i_flush(flush), .o_valid(a_ov), .o_ready(ordy), .o_class(a_class), .o_votes(a_votes),
      .o_window_full(a_full), .o_drop(a_drop)
   );

   prediction_vote_filter #(
      .NUM_CLASSES(NC), .CLASS_WIDTH(2), .WINDOW(WIN), .CNT_WIDTH(3), .EMIT_PARTIAL(0)
   ) dut_b (
      .clk(clk), .rst(rst), .i_valid(valid & sel), .i_ready(b_ready), .i_class(cls),
      .i_flush(flush), .o_valid(b_ov), .o_ready(ordy), .o_class(b_class), .o_votes(b_votes),
      .o_window_full(b_full), .o_drop(b_drop)
   );

   always_comb begin
      rdy    = sel ? b_ready : a_ready;
      ov     = sel ? b_ov    : a_ov;
      ocls   = sel ? b_class : a_class;
      ovotes = sel ? b_votes : a_votes;
      ofull  = sel ? b_full  : a_full;
      odrop  = sel ? b_drop  : a_drop;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: keep the last WIN classes, count them, pick max with newest-then-lowest tie-break.
   task automatic model_push(input int c, output int wc, output int wv);
      int cnt [NC];
      int best;
      win.push_back(c);
      if (win.size() > WIN) win.delete(0);
      for (int i = 0; i < NC; i++) cnt[i] = 0;
      foreach (win[i]) cnt[win[i]]++;
      best = 0;
      for (int i = 0; i < NC; i++) if (cnt[i] > best) best = cnt[i];
      wv = best;
      wc = -1;
      if (cnt[c] == best) wc = c;
      for (int i = 0; i < NC; i++) if (wc < 0 && cnt[i] == best) wc = i;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      win.delete();
      chk("flush_ov", ov, 0);
      chk("flush_full", ofull, 0);
      chk("flush_ready", rdy, 1);
   endtask

   // One prediction through the selected DUT; hold = cycles of o_ready=0 once o_valid rises.
   task automatic send(input int c, input int hold);
      int  ec, ev;
      bit  full, emit;
      logic [31:0] cv;
      cv = c;
      chk("idle_ready", rdy, 1);
      cls   = cv[1:0];
      valid = 1'b1;
      ordy  = (hold == 0);
      @(posedge clk); #1;
      valid = 1'b0;
      if (c >= NC) begin
         chk("drop_pulse", odrop, 1);
         chk("drop_no_valid", ov, 0);
         @(posedge clk); #1;
         chk("drop_once", odrop, 0);
         chk("drop_ready", rdy, 1);
         chk("drop_no_valid2", ov, 0);
         ordy = 1'b1;
         return;
      end
      chk("drop_quiet", odrop, 0);
      chk("busy_ready", rdy, 0);
      model_push(c, ec, ev);
      full = (win.size() == WIN);
      emit = (sel == 1'b0) || full;
      @(posedge clk); #1;
      chk("lat_t2_valid", ov, 0);
      @(posedge clk); #1;
      chk("window_full", ofull, full);
      if (!emit) begin
         chk("no_emit_valid", ov, 0);
         chk("no_emit_ready", rdy, 1);
         ordy = 1'b1;
         return;
      end
      chk("o_valid", ov, 1);
      chk("o_class", ocls, ec);
      chk("o_votes", ovotes, ev);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk("hold_valid", ov, 1);
         chk("hold_class", ocls, ec);
         chk("hold_votes", ovotes, ev);
         chk("hold_ready", rdy, 0);
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      chk("retire_valid", ov, 0);
      chk("retire_ready", rdy, 1);
   endtask

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      cls   = '0;
      flush = 1'b0;
      ordy  = 1'b1;
      sel   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_a_ov", a_ov, 0);
      chk("rst_a_class", a_class, 0);
      chk("rst_a_votes", a_votes, 0);
      chk("rst_a_full", a_full, 0);
      chk("rst_a_drop", a_drop, 0);
      chk("rst_a_ready", a_ready, 1);
      chk("rst_b_ov", b_ov, 0);
      chk("rst_b_ready", b_ready, 1);

      send(2, 0);
      do_flush();
      send(0, 0);
      send(1, 0);
      send(1, 0);
      send(2, 0);
      send(1, 0);
      send(2, 0);
      send(2, 0);
      send(2, 0);

      send(0, 10);

      do_flush();
      send(3, 0);
      send(0, 0);

      cls   = 2'd0;
      valid = 1'b1;
      ordy  = 1'b0;
      @(posedge clk); #1;
      valid = 1'b0;
      begin
         int ec, ev;
         model_push(0, ec, ev);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_flush_valid", ov, 1);
      flush = 1'b1;
      valid = 1'b1;
      cls   = 2'd2;
      @(posedge clk); #1;
      flush = 1'b0;
      valid = 1'b0;
      ordy  = 1'b1;
      win.delete();
      chk("flush_out_valid", ov, 0);
      chk("flush_out_full", ofull, 0);
      chk("flush_no_accept", rdy, 1);
      chk("flush_no_drop", odrop, 0);
      send(1, 0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) do_flush();
         send(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      do_flush();
      sel = 1'b1;
      do_flush();
      for (int n = 0; n < 4; n++) send(int'($urandom_range(0, 2)), 0);
      send(int'($urandom_range(0, 2)), 0);
      chk("partial0_full", ofull, 1);
      for (int n = 0; n < 12; n++) send(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
